// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: anode codes,
// source-select FSM encoding and digit-index type.
package seg_pkg;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    typedef enum logic {
        PRIMARY = 1'b0,
        ALT     = 1'b1
    } src_state_t;

    typedef logic [1:0] dig_t;

    function automatic logic [3:0] an_onehot(input dig_t d);
        case (d)
            2'd0:    return AN_DIG0;
            2'd1:    return AN_DIG1;
            2'd2:    return AN_DIG2;
            default: return AN_DIG3;
        endcase
    endfunction

    // True when digit d and everything to its left are zero; digit 0 never blanks.
    function automatic logic lz_blank(input logic [15:0] v, input dig_t d);
        case (d)
            2'd1:    return (v[15:4] == 12'h000);
            2'd2:    return (v[15:8] == 8'h00);
            2'd3:    return (v[15:12] == 4'h0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Display-side bundle: value inputs, alternate request handshake, and the
// anode/nibble outputs of the scan scheduler.
interface seg_scan_scheduler_if;
    logic [15:0] count;
    logic [15:0] alt_value;
    logic        alt_req;
    logic        alt_ack;
    logic [3:0]  AN;
    logic [3:0]  four;

    modport master (
        output count, alt_value, alt_req,
        input  alt_ack, AN, four
    );

    modport slave (
        input  count, alt_value, alt_req,
        output alt_ack, AN, four
    );
endinterface

// File: rtl/seg_scan_prescaler.sv
// Digit-slot timebase: counts 0..SCAN_DIV-1 and flags the last count.
module seg_scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = $clog2(SCAN_DIV);
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] pre;

    assign tick = (pre == LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + W'(1);
        end
    end
endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit scan controller with primary/alternate source arbitration.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_LZ_EN.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_scan_scheduler_if.slave  bus
);
    logic        tick;
    logic        boundary;
    dig_t        dig_q, dig_next;
    src_state_t  state_q, state_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] hold_q, hold_d;
    logic        cooldown_q, cooldown_d;
    logic        ack_q, ack_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  four_q, four_d;

    seg_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary = tick && (dig_q == 2'd3);
    assign dig_next = dig_q + 2'd1;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        hold_d     = hold_q;
        cooldown_d = cooldown_q;
        ack_d      = 1'b0;
        if (boundary) begin
            case (state_q)
                PRIMARY: begin
                    if (bus.alt_req && !cooldown_q) begin
                        snap_d  = bus.alt_value;
                        ack_d   = 1'b1;
                        hold_d  = 16'(HOLD_FRAMES - 1);
                        state_d = ALT;
                    end else begin
                        snap_d     = bus.count;
                        cooldown_d = 1'b0;
                    end
                end
                default: begin
                    if (hold_q == 16'd0) begin
                        snap_d     = bus.count;
                        cooldown_d = 1'b1;
                        state_d    = PRIMARY;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // The nibble and blanking look at snap_d so a frame boundary shows the new value at once.
    always_comb begin
        four_d = snap_d[{dig_next, 2'b00} +: 4];
`ifdef SEG_BLANK_LZ_EN
        an_d = lz_blank(snap_d, dig_next) ? AN_OFF : an_onehot(dig_next);
`else
        an_d = an_onehot(dig_next);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_q      <= 2'd3;
            state_q    <= PRIMARY;
            snap_q     <= '0;
            hold_q     <= '0;
            cooldown_q <= 1'b0;
            ack_q      <= 1'b0;
            an_q       <= AN_OFF;
            four_q     <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            hold_q     <= hold_d;
            cooldown_q <= cooldown_d;
            ack_q      <= ack_d;
            if (tick) begin
                dig_q  <= dig_next;
                an_q   <= an_d;
                four_q <= four_d;
            end
        end
    end

    assign bus.alt_ack = ack_q;
    assign bus.AN      = an_q;
    assign bus.four    = four_q;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed scoreboard bench for seg_scan_scheduler with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_seg_scan_scheduler;
    localparam int SCAN_DIV    = 4;
    localparam int HOLD_FRAMES = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] four;
        logic       ack;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    seg_scan_scheduler_if bus ();

    seg_scan_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected slot for digit d when the frame value is val.
    task automatic push_digit(input int d, input logic [15:0] val, input logic ack);
        exp_t        e;
        logic [15:0] upper;
        upper  = val >> (4 * d);
        e.four = upper[3:0];
        e.an   = ~(4'b0001 << d);
`ifdef SEG_BLANK_LZ_EN
        if (d > 0 && upper == 16'h0000) e.an = 4'b1111;
`endif
        e.ack = ack;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] val, input logic ack);
        push_digit(0, val, ack);
        for (int d = 1; d < 4; d++) push_digit(d, val, 1'b0);
    endtask

    task automatic push_blank_slot();
        exp_t e;
        e.an   = 4'b1111;
        e.four = 4'h0;
        e.ack  = 1'b0;
        sb.push_back(e);
    endtask

    // Called at a negedge at the start of a slot; consumes the queue one slot at a time.
    task automatic run_slots(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < SCAN_DIV; k++) begin
                check({tag, ".AN"}, 16'(bus.AN), 16'(e.an));
                check({tag, ".four"}, 16'(bus.four), 16'(e.four));
                check({tag, ".ack"}, 16'(bus.alt_ack), (k == 0) ? 16'(e.ack) : 16'h0);
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.count     = 16'h1234;
        bus.alt_value = 16'h0000;
        bus.alt_req   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.AN", 16'(bus.AN), 16'h000F);
        check("reset.four", 16'(bus.four), 16'h0000);
        check("reset.ack", 16'(bus.alt_ack), 16'h0000);
        reset = 1'b0;

        // Startup scan of a held primary value.
        push_blank_slot();
        push_frame(16'h1234, 1'b0);
        push_frame(16'h1234, 1'b0);
        run_slots("scan");

        // Count change while digit 1 is on screen stays out of the current frame.
        push_digit(0, 16'h1234, 1'b0);
        run_slots("mid0");
        bus.count = 16'hABCD;
        push_digit(1, 16'h1234, 1'b0);
        push_digit(2, 16'h1234, 1'b0);
        push_digit(3, 16'h1234, 1'b0);
        push_frame(16'hABCD, 1'b0);
        run_slots("mid");

        // Alternate request: two held frames, cooldown frames, then re-acceptance.
        bus.count     = 16'h1234;
        bus.alt_value = 16'h00EE;
        bus.alt_req   = 1'b1;
        push_frame(16'hABCD, 1'b0);
        for (int f = 0; f < HOLD_FRAMES; f++) push_frame(16'h00EE, f == 0);
        push_frame(16'h1234, 1'b0);
        push_frame(16'h1234, 1'b0);
        push_digit(0, 16'h00EE, 1'b1);
        run_slots("alt");

        // One-cycle reset while in ALT; requester still holding alt_req is re-served.
        reset = 1'b1;
        @(negedge clk);
        check("rst_alt.AN", 16'(bus.AN), 16'h000F);
        check("rst_alt.four", 16'(bus.four), 16'h0000);
        check("rst_alt.ack", 16'(bus.alt_ack), 16'h0000);
        reset = 1'b0;
        push_blank_slot();
        for (int f = 0; f < HOLD_FRAMES; f++) push_frame(16'h00EE, f == 0);
        run_slots("restart");

        // Leading-zero values.
        bus.alt_req = 1'b0;
        bus.count   = 16'h0050;
        push_frame(16'h1234, 1'b0);
        push_frame(16'h0050, 1'b0);
        run_slots("lz50");
        bus.count = 16'h0000;
        push_frame(16'h0050, 1'b0);
        push_frame(16'h0000, 1'b0);
        run_slots("lz00");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
